// File: rtl/intersection_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_scheduler
// Traffic-light phase sequencer for a two-approach intersection (NS and EW).
// Each approach has a protected left-arrow phase, an actuated through-green
// with gap-out and a max-out, then yellow and all-red clearance. An emergency
// preempt brings the active approach through yellow and holds both approaches
// at all-red until the request drops.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   emergency    in   level preempt request
//   ns_car       in   NS through-vehicle sensor
//   ew_car       in   EW through-vehicle sensor
//   ns_left_req  in   NS left-turn request
//   ew_left_req  in   EW left-turn request
//   ns_out       out  NS lamps {left, green, yellow, red}
//   ew_out       out  EW lamps, same encoding
//   phase        out  current state code (0..8)
//   allstop      out  high only while in PREEMPT
// -----------------------------------------------------------------------------
module intersection_scheduler #(
   parameter int unsigned T_LEFT      = 5,
   parameter int unsigned T_MIN_GREEN = 6,
   parameter int unsigned T_MAX_GREEN = 10,
   parameter int unsigned T_YELLOW    = 3,
   parameter int unsigned T_CLEAR     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       emergency,
   input  logic       ns_car,
   input  logic       ew_car,
   input  logic       ns_left_req,
   input  logic       ew_left_req,
   output logic [3:0] ns_out,
   output logic [3:0] ew_out,
   output logic [3:0] phase,
   output logic       allstop
);

   localparam int unsigned CNT_W   = 5;
   localparam int unsigned LAMP_W  = 4;

   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(31);
   localparam logic [CNT_W-1:0] LEFT_LAST = CNT_W'(T_LEFT - 1);
   localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(T_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(T_MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YELLOW - 1);
   localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(T_CLEAR - 1);

   localparam logic [LAMP_W-1:0] LAMP_LEFT   = 4'b1001;
   localparam logic [LAMP_W-1:0] LAMP_GREEN  = 4'b0100;
   localparam logic [LAMP_W-1:0] LAMP_YELLOW = 4'b0010;
   localparam logic [LAMP_W-1:0] LAMP_RED    = 4'b0001;

   typedef enum logic [3:0] {
      NS_LEFT   = 4'd0,
      NS_GREEN  = 4'd1,
      NS_YELLOW = 4'd2,
      NS_CLEAR  = 4'd3,
      EW_LEFT   = 4'd4,
      EW_GREEN  = 4'd5,
      EW_YELLOW = 4'd6,
      EW_CLEAR  = 4'd7,
      PREEMPT   = 4'd8
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ns_pend_q, ns_pend_d;
   logic              ew_pend_q, ew_pend_d;
   logic              ns_left_pend_q, ns_left_pend_d;
   logic              ew_left_pend_q, ew_left_pend_d;
   logic              last_ew_q, last_ew_d;
   logic [LAMP_W-1:0] ns_out_q, ns_out_d;
   logic [LAMP_W-1:0] ew_out_q, ew_out_d;
   logic              allstop_q, allstop_d;

   // Opposing demand seen by the approach currently holding green
   logic ns_opp_c;
   logic ew_opp_c;
   logic state_chg_c;

   assign ns_opp_c    = ew_pend_q | ew_left_pend_q;
   assign ew_opp_c    = ns_pend_q | ns_left_pend_q;
   assign state_chg_c = (state_d != state_q);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         NS_LEFT: begin
            if (emergency)               state_d = NS_YELLOW;
            else if (cnt_q == LEFT_LAST) state_d = NS_GREEN;
         end
         NS_GREEN: begin
            // >= on max-out covers demand arriving after a long rest
            if (emergency)
               state_d = NS_YELLOW;
            else if (ns_opp_c && ((cnt_q >= MAX_LAST) || ((cnt_q >= MIN_LAST) && !ns_car)))
               state_d = NS_YELLOW;
         end
         NS_YELLOW: begin
            if (cnt_q == YEL_LAST) state_d = emergency ? PREEMPT : NS_CLEAR;
         end
         NS_CLEAR: begin
            if (emergency)              state_d = PREEMPT;
            else if (cnt_q == CLR_LAST) state_d = ew_left_pend_q ? EW_LEFT : EW_GREEN;
         end
         EW_LEFT: begin
            if (emergency)               state_d = EW_YELLOW;
            else if (cnt_q == LEFT_LAST) state_d = EW_GREEN;
         end
         EW_GREEN: begin
            if (emergency)
               state_d = EW_YELLOW;
            else if (ew_opp_c && ((cnt_q >= MAX_LAST) || ((cnt_q >= MIN_LAST) && !ew_car)))
               state_d = EW_YELLOW;
         end
         EW_YELLOW: begin
            if (cnt_q == YEL_LAST) state_d = emergency ? PREEMPT : EW_CLEAR;
         end
         EW_CLEAR: begin
            if (emergency)              state_d = PREEMPT;
            else if (cnt_q == CLR_LAST) state_d = ns_left_pend_q ? NS_LEFT : NS_GREEN;
         end
         PREEMPT: begin
            // Resume with the clearance of the approach that was last served
            if (!emergency) state_d = last_ew_q ? EW_CLEAR : NS_CLEAR;
         end
         default: state_d = EW_CLEAR;
      endcase
   end

   // Phase counter, pending-request latches and last-served direction
   always_comb begin
      cnt_d          = cnt_q;
      ns_pend_d      = ns_pend_q | ns_car;
      ew_pend_d      = ew_pend_q | ew_car;
      ns_left_pend_d = ns_left_pend_q | ns_left_req;
      ew_left_pend_d = ew_left_pend_q | ew_left_req;
      last_ew_d      = last_ew_q;

      if (state_chg_c)            cnt_d = '0;
      else if (cnt_q != CNT_MAX)  cnt_d = cnt_q + CNT_W'(1);

      // Entry into a served phase clears its request, even against a new set
      if (state_chg_c) begin
         if (state_d == NS_GREEN) ns_pend_d      = 1'b0;
         if (state_d == EW_GREEN) ew_pend_d      = 1'b0;
         if (state_d == NS_LEFT)  ns_left_pend_d = 1'b0;
         if (state_d == EW_LEFT)  ew_left_pend_d = 1'b0;
      end

      unique case (state_q)
         NS_LEFT, NS_GREEN, NS_YELLOW, NS_CLEAR: last_ew_d = 1'b0;
         EW_LEFT, EW_GREEN, EW_YELLOW, EW_CLEAR: last_ew_d = 1'b1;
         default:                                last_ew_d = last_ew_q;
      endcase
   end

   // Lamp decode from the next state so the registered lamps track state_q
   always_comb begin
      ns_out_d  = LAMP_RED;
      ew_out_d  = LAMP_RED;
      allstop_d = 1'b0;
      unique case (state_d)
         NS_LEFT:   ns_out_d  = LAMP_LEFT;
         NS_GREEN:  ns_out_d  = LAMP_GREEN;
         NS_YELLOW: ns_out_d  = LAMP_YELLOW;
         EW_LEFT:   ew_out_d  = LAMP_LEFT;
         EW_GREEN:  ew_out_d  = LAMP_GREEN;
         EW_YELLOW: ew_out_d  = LAMP_YELLOW;
         PREEMPT:   allstop_d = 1'b1;
         default:   ;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= EW_CLEAR;
         cnt_q          <= '0;
         ns_pend_q      <= 1'b0;
         ew_pend_q      <= 1'b0;
         ns_left_pend_q <= 1'b0;
         ew_left_pend_q <= 1'b0;
         last_ew_q      <= 1'b1;
         ns_out_q       <= LAMP_RED;
         ew_out_q       <= LAMP_RED;
         allstop_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         ns_pend_q      <= ns_pend_d;
         ew_pend_q      <= ew_pend_d;
         ns_left_pend_q <= ns_left_pend_d;
         ew_left_pend_q <= ew_left_pend_d;
         last_ew_q      <= last_ew_d;
         ns_out_q       <= ns_out_d;
         ew_out_q       <= ew_out_d;
         allstop_q      <= allstop_d;
      end
   end

   assign phase   = state_q;
   assign ns_out  = ns_out_q;
   assign ew_out  = ew_out_q;
   assign allstop = allstop_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// -----------------------------------------------------------------------------
// tb_intersection_scheduler
// Directed, table-driven bench for intersection_scheduler with default
// parameters. Each table row drives one input pattern for a number of cycles
// and checks phase/lamps/allstop after every clock edge.
// -----------------------------------------------------------------------------
module tb_intersection_scheduler;

   localparam logic [3:0] R = 4'b0001;
   localparam logic [3:0] G = 4'b0100;
   localparam logic [3:0] Y = 4'b0010;
   localparam logic [3:0] L = 4'b1001;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       emergency = 1'b0;
   logic       ns_car = 1'b0;
   logic       ew_car = 1'b0;
   logic       ns_left_req = 1'b0;
   logic       ew_left_req = 1'b0;
   logic [3:0] ns_out;
   logic [3:0] ew_out;
   logic [3:0] phase;
   logic       allstop;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic       rst;
      logic       em;
      logic       nsc;
      logic       ewc;
      logic       nsl;
      logic       ewl;
      int         reps;
      logic [3:0] ph;
      logic [3:0] ns;
      logic [3:0] ew;
      logic       as;
   } vec_t;

   vec_t tbl[$];

   intersection_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .emergency   (emergency),
      .ns_car      (ns_car),
      .ew_car      (ew_car),
      .ns_left_req (ns_left_req),
      .ew_left_req (ew_left_req),
      .ns_out      (ns_out),
      .ew_out      (ew_out),
      .phase       (phase),
      .allstop     (allstop)
   );

   always #5 clk = ~clk;

   task automatic add(input logic rst, input logic em, input logic nsc, input logic ewc,
                      input logic nsl, input logic ewl, input int reps,
                      input logic [3:0] ph, input logic [3:0] ns, input logic [3:0] ew,
                      input logic as);
      vec_t v;
      v.rst = rst; v.em = em; v.nsc = nsc; v.ewc = ewc; v.nsl = nsl; v.ewl = ewl;
      v.reps = reps; v.ph = ph; v.ns = ns; v.ew = ew; v.as = as;
      tbl.push_back(v);
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge
   task automatic step(input logic rst, input logic em, input logic nsc, input logic ewc,
                       input logic nsl, input logic ewl);
      reset = rst; emergency = em; ns_car = nsc; ew_car = ewc;
      ns_left_req = nsl; ew_left_req = ewl;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [3:0] ph, input logic [3:0] ns,
                      input logic [3:0] ew, input logic as);
      vectors++;
      if (phase !== ph || ns_out !== ns || ew_out !== ew || allstop !== as) begin
         miscompares++;
         $display("FAIL %s: got phase=%0d ns=%b ew=%b allstop=%b, expected phase=%0d ns=%b ew=%b allstop=%b",
                  name, phase, ns_out, ew_out, allstop, ph, ns, ew, as);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   initial begin
      int n;
      bit seen;

      // idle after reset: 2 cycles of EW clear, then NS green rests
      add(1,0,0,0,0,0,  1, 4'd7, R, R, 0);
      add(0,0,0,0,0,0,  1, 4'd7, R, R, 0);
      add(0,0,0,0,0,0, 52, 4'd1, G, R, 0);
      // reset beats emergency; NS max-out with ns_car held
      add(1,1,0,0,0,0,  1, 4'd7, R, R, 0);
      add(0,0,0,0,0,0,  1, 4'd7, R, R, 0);
      add(0,0,1,0,0,0,  1, 4'd1, G, R, 0);
      add(0,0,1,1,0,0,  1, 4'd1, G, R, 0);
      add(0,0,1,0,0,0,  8, 4'd1, G, R, 0);
      add(0,0,1,0,0,0,  3, 4'd2, Y, R, 0);
      add(0,0,0,0,0,0,  2, 4'd3, R, R, 0);
      add(0,0,0,0,0,0,  1, 4'd5, R, G, 0);
      // EW gaps out at minimum green against latched NS demand
      add(0,0,0,0,0,0,  5, 4'd5, R, G, 0);
      add(0,0,0,0,0,0,  3, 4'd6, R, Y, 0);
      add(0,0,0,0,0,0,  2, 4'd7, R, R, 0);
      add(0,0,0,0,0,0,  1, 4'd1, G, R, 0);
      // NS gap-out after exactly 6 green cycles
      add(0,0,0,1,0,0,  1, 4'd1, G, R, 0);
      add(0,0,0,0,0,0,  4, 4'd1, G, R, 0);
      add(0,0,0,0,0,0,  3, 4'd2, Y, R, 0);
      add(0,0,0,0,0,0,  2, 4'd3, R, R, 0);
      add(0,0,0,0,0,0,  1, 4'd5, R, G, 0);
      // NS left request during EW green -> NS left arrow for 5 cycles
      add(0,0,0,0,1,0,  1, 4'd5, R, G, 0);
      add(0,0,0,0,0,0,  4, 4'd5, R, G, 0);
      add(0,0,0,0,0,0,  3, 4'd6, R, Y, 0);
      add(0,0,0,0,0,0,  2, 4'd7, R, R, 0);
      add(0,0,0,0,0,0,  5, 4'd0, L, R, 0);
      add(0,0,0,0,0,0,  1, 4'd1, G, R, 0);
      // emergency at NS green counter 3; EW left latched during preempt
      add(0,0,0,0,0,0,  3, 4'd1, G, R, 0);
      add(0,1,0,0,0,0,  1, 4'd2, Y, R, 0);
      add(0,1,0,0,0,0,  2, 4'd2, Y, R, 0);
      add(0,1,0,0,0,0,  1, 4'd8, R, R, 1);
      add(0,1,0,0,0,1,  1, 4'd8, R, R, 1);
      add(0,1,0,0,0,0,  3, 4'd8, R, R, 1);
      add(0,0,0,0,0,0,  2, 4'd3, R, R, 0);
      add(0,0,0,0,0,0,  5, 4'd4, R, L, 0);
      add(0,0,0,0,0,0,  1, 4'd5, R, G, 0);
      // emergency during EW clear -> preempt next cycle, resume EW clear
      add(0,0,1,0,0,0,  1, 4'd5, R, G, 0);
      add(0,0,0,0,0,0,  4, 4'd5, R, G, 0);
      add(0,0,0,0,0,0,  3, 4'd6, R, Y, 0);
      add(0,0,0,0,0,0,  1, 4'd7, R, R, 0);
      add(0,1,0,0,0,0,  1, 4'd8, R, R, 1);
      add(0,0,0,0,0,0,  2, 4'd7, R, R, 0);
      add(0,0,0,0,0,0,  1, 4'd1, G, R, 0);
      // reset during EW yellow with NS left pending -> plain NS green
      add(0,0,0,1,0,0,  1, 4'd1, G, R, 0);
      add(0,0,0,0,0,0,  4, 4'd1, G, R, 0);
      add(0,0,0,0,0,0,  3, 4'd2, Y, R, 0);
      add(0,0,0,0,0,0,  2, 4'd3, R, R, 0);
      add(0,0,0,0,0,0,  1, 4'd5, R, G, 0);
      add(0,0,0,0,1,0,  1, 4'd5, R, G, 0);
      add(0,0,0,0,0,0,  4, 4'd5, R, G, 0);
      add(0,0,0,0,0,0,  1, 4'd6, R, Y, 0);
      add(1,0,0,0,0,0,  1, 4'd7, R, R, 0);
      add(0,0,0,0,0,0,  1, 4'd7, R, R, 0);
      add(0,0,0,0,0,0,  1, 4'd1, G, R, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         for (int r = 0; r < tbl[i].reps; r++) begin
            step(tbl[i].rst, tbl[i].em, tbl[i].nsc, tbl[i].ewc, tbl[i].nsl, tbl[i].ewl);
            chk($sformatf("row%0d.%0d", i, r), tbl[i].ph, tbl[i].ns, tbl[i].ew, tbl[i].as);
         end
      end

      // Hand sequence: EW left request measured by phase durations
      step(1,0,0,0,0,0);
      chk("hs_reset", 4'd7, R, R, 0);
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step(0,0,0,0,0,0);
         if (phase == 4'd1) seen = 1;
      end
      chk_int("hs_reach_ns_green", int'(seen), 1);

      step(0,0,0,0,0,1);
      n = 2;
      for (int i = 0; i < 40; i++) begin
         step(0,0,0,0,0,0);
         if (phase != 4'd1) break;
         n++;
      end
      chk_int("hs_ns_green_len", n, 6);
      chk("hs_ns_yellow", 4'd2, Y, R, 0);

      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step(0,0,0,0,0,0);
         if (phase == 4'd4) seen = 1;
      end
      chk_int("hs_reach_ew_left", int'(seen), 1);
      chk("hs_ew_left_lamps", 4'd4, R, L, 0);
      n = 1;
      for (int i = 0; i < 40; i++) begin
         step(0,0,0,0,0,0);
         if (phase != 4'd4) break;
         n++;
      end
      chk_int("hs_ew_left_len", n, 5);
      chk("hs_ew_green", 4'd5, R, G, 0);

      // Emergency in a left arrow must go through yellow
      step(0,0,1,0,0,0);
      n = 0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step(0,0,0,0,0,0);
         if (phase == 4'd0) seen = 1;
      end
      chk_int("hs_reach_ns_left", int'(seen), 0);
      step(1,0,0,0,0,0);
      step(0,0,0,0,1,0);
      step(0,0,0,0,0,0);
      chk("hs_ns_left_entry", 4'd0, L, R, 0);
      step(0,1,0,0,0,0);
      chk("hs_left_emerg_yellow", 4'd2, Y, R, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 SHALL have parameter T_LEFT, default 5, left-arrow phase length in cycles.
REQ-002 SHALL have parameter T_MIN_GREEN, default 6, minimum green length in cycles.
REQ-003 SHALL have parameter T_MAX_GREEN, default 10, maximum green length in cycles when the opposing approach has demand.
REQ-004 SHALL have parameter T_YELLOW, default 3, yellow length in cycles.
REQ-005 SHALL have parameter T_CLEAR, default 2, all-red clearance length in cycles.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have these ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- emergency  in  1  level preempt request
- ns_car  in  1  NS through-vehicle sensor
- ew_car  in  1  EW through-vehicle sensor
- ns_left_req  in  1  NS left-turn request
- ew_left_req  in  1  EW left-turn request
- ns_out  out  4  NS lamps {left, green, yellow, red}
- ew_out  out  4  EW lamps, same encoding
- phase  out  4  current state code
- allstop  out  1  high only in PREEMPT

Function
REQ-008 SHALL implement states with these phase codes: 0 NS_LEFT, 1 NS_GREEN, 2 NS_YELLOW, 3 NS_CLEAR, 4 EW_LEFT, 5 EW_GREEN, 6 EW_YELLOW, 7 EW_CLEAR, 8 PREEMPT.
REQ-009 SHALL decode outputs from the state register only (Moore): served approach LEFT=1001, GREEN=0100, YELLOW=0010; every other approach and state=0001.
REQ-010 SHALL keep a 5-bit phase counter that clears to 0 on every state change, increments each cycle otherwise, and saturates at 31.
REQ-011 SHALL occupy a timed state of length T for exactly T cycles, leaving when counter==T-1.
REQ-012 SHALL latch four pending flags: ns_pend, ew_pend, ns_left_pend, ew_left_pend, each set by its input, cleared on entry to its GREEN or LEFT state; clear wins over a simultaneous set.
REQ-013 SHALL take X_CLEAR -> opposite Y_LEFT if Y_left_pend, else Y_GREEN.
REQ-014 SHALL take X_LEFT -> X_GREEN after T_LEFT cycles.
REQ-015 SHALL define opposing demand for X as Y_pend | Y_left_pend.
REQ-016 SHALL in X_GREEN with opposing demand go to X_YELLOW when counter==T_MAX_GREEN-1, or earlier when counter>=T_MIN_GREEN-1 and X_car==0 (gap-out).
REQ-017 SHALL in X_GREEN without opposing demand rest in X_GREEN indefinitely.
REQ-018 SHALL take X_YELLOW -> X_CLEAR after T_YELLOW cycles.
REQ-019 SHALL on emergency==1 in X_LEFT or X_GREEN go to X_YELLOW next cycle, never directly to red.
REQ-020 SHALL on emergency==1 in X_YELLOW finish yellow, then go to PREEMPT instead of X_CLEAR.
REQ-021 SHALL on emergency==1 in X_CLEAR go to PREEMPT next cycle.
REQ-022 SHALL in PREEMPT record last served direction X and hold while emergency==1; on emergency==0 go to X_CLEAR, counter 0.
REQ-023 SHALL keep pending flags latching during PREEMPT.
REQ-024 SHALL be valid only for parameters with every length >=1, T_MIN_GREEN<=T_MAX_GREEN<=31.

Reset
REQ-025 SHALL on reset==1 at a clock edge force state EW_CLEAR (phase=7), counter=0, all pending flags=0, last direction=EW, ns_out=ew_out=0001, allstop=0.
REQ-026 SHALL give reset priority over emergency and all other inputs in the same cycle, including reset mid-phase.

Verification
REQ-027 SHALL cover: reset, idle inputs -> phase=7 for 2 cycles, then phase=1, ns_out=0100 held 50+ cycles.
REQ-028 SHALL cover: ew_car pulse in NS_GREEN cycle 0, ns_car held 1 -> NS green 10 cycles, 0010 3 cycles, all-red 2 cycles, then ew_out=0100.
REQ-029 SHALL cover: ew_car pulse, ns_car=0 -> NS green exits after exactly 6 cycles.
REQ-030 SHALL cover: ns_left_req pulse during EW_GREEN, ns_car=0 -> after EW yellow/clear, ns_out=1001 for 5 cycles, then 0100.
REQ-031 SHALL cover: emergency at NS_GREEN counter 3 -> NS_YELLOW next cycle for 3 cycles, then phase=8, allstop=1, both 0001 until release; release -> phase=3 for 2 cycles, then EW service.
REQ-032 SHALL cover: reset during EW_YELLOW with ns_left_pend set -> phase=7 next cycle, pending cleared, NS_GREEN (not NS_LEFT) after 2 cycles.
